// File: rtl/cam_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
//
// Shared definitions for the CAM write path:
//   - CAM_WIDTH   : default number of CAM entries used across the CAM blocks
//   - state_e     : FSM encoding for cam_addr_decoder (ST_IDLE / ST_CLEAR)
//   - OP_INVAL /
//     OP_SET      : request op encoding, shared with the CAM controller
//   - addr_width(): index width for a given entry count (minimum 1 bit so a
//                   single-entry CAM still has a legal index port)
// -----------------------------------------------------------------------------
package cam_pkg;

    localparam int CAM_WIDTH = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam logic OP_INVAL = 1'b0;
    localparam logic OP_SET   = 1'b1;

    function automatic int addr_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// -----------------------------------------------------------------------------
// onehot_decoder
//
// Purely combinational index -> one-hot row select. This is the inverse of
// the match encoder's 2:1 reduction slices: exactly one bit of onehot is set
// when addr names an existing row, none otherwise.
//
// Parameters:
//   WIDTH  : number of rows (need not be a power of two)
//   ADDR_W : index width
// Ports:
//   addr     in  ADDR_W  row index
//   onehot   out WIDTH   one-hot row select (all-zero when addr >= WIDTH)
//   in_range out 1       addr < WIDTH
// -----------------------------------------------------------------------------
module onehot_decoder #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [WIDTH-1:0]  onehot,
    output logic              in_range
);

    // One comparator per row; rows beyond the index space simply never
    // exist, so an out-of-range address naturally yields an all-zero vector.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row
        assign onehot[gi] = (addr == ADDR_W'(gi));
    end

    // Explicit range check rather than |onehot so the flag stays correct
    // even if the row comparators are ever restructured.
    assign in_range = ({{(32-ADDR_W){1'b0}}, addr} < 32'(WIDTH));

endmodule

// File: rtl/cam_addr_decoder.sv
// -----------------------------------------------------------------------------
// cam_addr_decoder
//
// Write side of the CAM: turns an encoded entry index plus op into a
// registered one-hot row write-enable, keeps a per-entry valid map, and runs
// a one-row-per-cycle clear-all sweep.
//
// Parameters:
//   WIDTH  : number of CAM entries (>= 1, any value)
//   ADDR_W : index width (1 when WIDTH == 1)
// Ports:
//   clk          in  1       clock, all state on posedge
//   rst          in  1       asynchronous active-high reset
//   in_valid     in  1       request present
//   in_ready     out 1       request accepted when in_valid && in_ready
//   in_addr      in  ADDR_W  target entry index
//   in_op        in  1       OP_SET = mark valid, OP_INVAL = invalidate
//   clear_all    in  1       invalidate every entry (level, sampled in IDLE)
//   out_we       out WIDTH   registered one-hot row write-enable
//   out_set      out 1       registered row valid-bit value (with out_we)
//   entry_valid  out WIDTH   registered valid map
//   full         out 1       every entry valid
//   busy         out 1       clear sweep in progress
//   err          out 1       one-cycle pulse: accepted in_addr >= WIDTH
// -----------------------------------------------------------------------------
module cam_addr_decoder
    import cam_pkg::*;
#(
    parameter int WIDTH  = CAM_WIDTH,
    parameter int ADDR_W = addr_width(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_op,
    input  logic              clear_all,
    output logic [WIDTH-1:0]  out_we,
    output logic              out_set,
    output logic [WIDTH-1:0]  entry_valid,
    output logic              full,
    output logic              busy,
    output logic              err
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]   out_we_q, out_we_d;
    logic               out_set_q, out_set_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   entry_valid_q, entry_valid_d;

    // -------------------------------------------------------------------------
    // Shared row decoder
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0]  dec_addr;
    logic [WIDTH-1:0]   dec_onehot;
    logic               dec_in_range;
    logic               sweep_sel;

    // The sweep counter drives the decoder whenever a clear row is being
    // written. cnt_q always rests at 0 in IDLE, so the first row of a fresh
    // clear_all comes from the same path as the rest of the sweep.
    assign sweep_sel = (state_q == ST_CLEAR) || clear_all;
    assign dec_addr  = sweep_sel ? cnt_q : in_addr;

    onehot_decoder #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_dec (
        .addr     (dec_addr),
        .onehot   (dec_onehot),
        .in_range (dec_in_range)
    );

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        out_we_d      = '0;
        out_set_d     = out_set_q;     // only meaningful alongside out_we
        err_d         = 1'b0;
        entry_valid_d = entry_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (clear_all) begin
                    // Row 0 is cleared on the accepting edge itself.
                    out_we_d      = dec_onehot;
                    out_set_d     = 1'b0;
                    entry_valid_d = entry_valid_q & ~dec_onehot;
                    if (WIDTH > 1) begin
                        cnt_d   = ADDR_W'(1);
                        state_d = ST_CLEAR;
                    end
                end else if (in_valid) begin
                    if (dec_in_range) begin
                        out_we_d  = dec_onehot;
                        out_set_d = in_op;
                        if (in_op == OP_SET) begin
                            entry_valid_d = entry_valid_q | dec_onehot;
                        end else begin
                            entry_valid_d = entry_valid_q & ~dec_onehot;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_CLEAR: begin
                // Requests and clear_all are not looked at here; in_ready is
                // low for the whole sweep so nothing is lost upstream.
                out_we_d      = dec_onehot;
                out_set_d     = 1'b0;
                entry_valid_d = entry_valid_q & ~dec_onehot;
                if (cnt_q == ADDR_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            out_we_q      <= '0;
            out_set_q     <= 1'b0;
            err_q         <= 1'b0;
            entry_valid_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            out_we_q      <= out_we_d;
            out_set_q     <= out_set_d;
            err_q         <= err_d;
            entry_valid_q <= entry_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready    = (state_q == ST_IDLE) && !clear_all;
    assign out_we      = out_we_q;
    assign out_set     = out_set_q;
    assign err         = err_q;
    assign entry_valid = entry_valid_q;
    assign full        = &entry_valid_q;
    assign busy        = (state_q == ST_CLEAR);

endmodule
